// File: rtl/plantard_mm_arbiter_if.sv
// rtl/plantard_mm_arbiter_if.sv - requester, multiplier and response bundle for the plantard_mm arbiter
interface plantard_mm_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 12
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      mm_a;
  logic [DW-1:0]      mm_c;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;

  modport master (
    output req_valid, req_data, mm_c,
    input  req_ready, mm_a, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, mm_c,
    output req_ready, mm_a, rsp_valid, rsp_data
  );
endinterface

// File: rtl/plantard_mm_arbiter.sv
// rtl/plantard_mm_arbiter.sv - round-robin sharing of one pipelined plantard_mm multiplier
module plantard_mm_arbiter #(
  parameter int NREQ   = 4,
  parameter int DW     = 12,
  parameter int MM_LAT = 4,
  parameter int TAGW   = $clog2(NREQ),
  parameter int CNTW   = $clog2(MM_LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  plantard_mm_arbiter_if.slave   bus,
  input  logic                   hold,
  output logic [CNTW-1:0]        inflight,
  output logic                   idle
);

  logic [TAGW-1:0] ptr;
  logic            grant;
  logic [TAGW-1:0] gnt_idx;
  logic [TAGW:0]   sum;
  logic [TAGW-1:0] idx;

  logic [MM_LAT-1:0] tag_v;
  logic [TAGW-1:0]   tag_id [MM_LAT];

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr} + (TAGW+1)'(off);
      if (sum >= (TAGW+1)'(NREQ)) sum = sum - (TAGW+1)'(NREQ);
      idx = sum[TAGW-1:0];
      if (!grant && bus.req_valid[idx]) begin
        grant   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (!rst || hold) begin
      grant   = 1'b0;
      gnt_idx = '0;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.mm_a      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && gnt_idx == TAGW'(i)) begin
        bus.req_ready[i] = 1'b1;
        bus.mm_a         = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Tag stage MM_LAT-1 lines up with the product currently on mm_c.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr           <= '0;
      tag_v         <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      for (int i = 0; i < MM_LAT; i++) tag_id[i] <= '0;
    end else begin
      if (grant) ptr <= (gnt_idx == TAGW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      tag_v[0]  <= grant;
      tag_id[0] <= gnt_idx;
      for (int i = 1; i < MM_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      bus.rsp_valid <= '0;
      if (tag_v[MM_LAT-1]) begin
        bus.rsp_valid[tag_id[MM_LAT-1]] <= 1'b1;
        bus.rsp_data                    <= bus.mm_c;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MM_LAT; i++) inflight = inflight + CNTW'(tag_v[i]);
    idle = (inflight == '0) && (bus.rsp_valid == '0);
  end

endmodule
